clock_period_meter: RTL and testbench

Measures a slow clock-like signal against the board clock: high time, low time and period, all in clk_in cycles. It is the reading end of the frequency divider that produces the CPU's slow clock. Used for self-check of the divided CPU clock, debug LEDs and seven-segment display, and bench checks of the divide ratio. Input is asynchronous to clk_in, so it is synchronised internally.

---
 rtl/clock_period_meter.sv | 218 +++++++++++++++++++++
 tb/tb_clock_period_meter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_period_meter.sv
// ---------------------------------------------------------------------------
// clock_period_meter
//
// Measures a slow, clock-like signal against the board clock. It reports the
// last complete high time, low time and period of that signal, counted in
// clk_in cycles. sig_in is asynchronous to clk_in, so it passes through a
// two-flop synchroniser before any use.
//
// Ports:
//   clk_in      in   board clock; all registers are clocked on its posedge
//   rst_n       in   synchronous active-low reset
//   sig_in      in   asynchronous signal under measurement
//   level       out  synchronised level of sig_in
//   high_out    out  [CNT_W] last complete high time
//   low_out     out  [CNT_W] last complete low time
//   period_out  out  [CNT_W] high + low, saturating at all-ones
//   meas_valid  out  one-cycle pulse when the three measurements update
//   stalled     out  no edge seen for TIMEOUT cycles
// ---------------------------------------------------------------------------
module clock_period_meter #(
   parameter int CNT_W   = 28,
   parameter int TIMEOUT = 250000000
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             sig_in,
   output logic             level,
   output logic [CNT_W-1:0] high_out,
   output logic [CNT_W-1:0] low_out,
   output logic [CNT_W-1:0] period_out,
   output logic             meas_valid,
   output logic             stalled
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] TMO_VAL  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] TMO_M1   = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_HIGH  = 2'd2,
      ST_LOW   = 2'd3
   } state_t;

   state_t           state_r;
   state_t           fsm_nxt_s;
   state_t           state_nxt_s;

   logic             s1_r;
   logic             s2_r;
   logic             prev_r;
   logic [1:0]       sync_fill_r;
   logic [CNT_W-1:0] hi_cnt_r;
   logic [CNT_W-1:0] lo_cnt_r;
   logic [CNT_W-1:0] st_cnt_r;

   logic             rise_s;
   logic             fall_s;
   logic             edge_s;
   logic             stall_hit_s;
   logic             sync_ready_s;
   logic             load_hi_s;
   logic             inc_hi_s;
   logic             load_lo_s;
   logic             inc_lo_s;
   logic             capture_s;
   logic [CNT_W-1:0] hi_inc_s;
   logic [CNT_W-1:0] lo_inc_s;
   logic [CNT_W:0]   sum_s;
   logic [CNT_W-1:0] period_s;

   assign level  = s2_r;
   assign rise_s = s2_r & ~prev_r;
   assign fall_s = ~s2_r & prev_r;
   assign edge_s = rise_s | fall_s;

   // The stall fires once, on the cycle the counter would reach TIMEOUT;
   // an edge in that same cycle takes priority.
   assign stall_hit_s = ~edge_s & (st_cnt_r == TMO_M1);

   // The synchroniser's reset zeros are not a real low level of sig_in. IDLE
   // only trusts s2 once sig_in has actually propagated through both flops,
   // otherwise a signal held high across reset would look like a fresh rise.
   assign sync_ready_s = sync_fill_r[1];

   assign hi_inc_s = (hi_cnt_r == CNT_MAX) ? CNT_MAX : (hi_cnt_r + CNT_ONE);
   assign lo_inc_s = (lo_cnt_r == CNT_MAX) ? CNT_MAX : (lo_cnt_r + CNT_ONE);
   assign sum_s    = {1'b0, hi_cnt_r} + {1'b0, lo_cnt_r};
   assign period_s = sum_s[CNT_W] ? CNT_MAX : sum_s[CNT_W-1:0];

   // Next-state and counter control strobes for the measurement FSM.
   always_comb begin
      fsm_nxt_s = state_r;
      load_hi_s = 1'b0;
      inc_hi_s  = 1'b0;
      load_lo_s = 1'b0;
      inc_lo_s  = 1'b0;
      capture_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (sync_ready_s && !s2_r) begin
               fsm_nxt_s = ST_ARMED;
            end else begin
               fsm_nxt_s = ST_IDLE;
            end
         end
         ST_ARMED: begin
            if (rise_s) begin
               fsm_nxt_s = ST_HIGH;
               load_hi_s = 1'b1;
            end else begin
               fsm_nxt_s = ST_ARMED;
            end
         end
         ST_HIGH: begin
            if (fall_s) begin
               fsm_nxt_s = ST_LOW;
               load_lo_s = 1'b1;
            end else begin
               fsm_nxt_s = ST_HIGH;
               inc_hi_s  = 1'b1;
            end
         end
         ST_LOW: begin
            if (rise_s) begin
               fsm_nxt_s = ST_HIGH;
               load_hi_s = 1'b1;
               capture_s = 1'b1;
            end else begin
               fsm_nxt_s = ST_LOW;
               inc_lo_s  = 1'b1;
            end
         end
         default: begin
            fsm_nxt_s = ST_IDLE;
         end
      endcase
      // A stall abandons any measurement in progress; stall_hit_s and
      // capture_s are mutually exclusive because capture needs an edge.
      state_nxt_s = stall_hit_s ? ST_IDLE : fsm_nxt_s;
   end

   // FSM state register.
   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Input synchroniser, edge history and synchroniser fill tracking.
   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         s1_r        <= 1'b0;
         s2_r        <= 1'b0;
         prev_r      <= 1'b0;
         sync_fill_r <= 2'b00;
      end else begin
         s1_r        <= sig_in;
         s2_r        <= s1_r;
         prev_r      <= s2_r;
         sync_fill_r <= {sync_fill_r[0], 1'b1};
      end
   end

   // High/low phase counters and the captured measurement outputs.
   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         hi_cnt_r   <= CNT_ZERO;
         lo_cnt_r   <= CNT_ZERO;
         high_out   <= CNT_ZERO;
         low_out    <= CNT_ZERO;
         period_out <= CNT_ZERO;
         meas_valid <= 1'b0;
      end else begin
         if (load_hi_s) begin
            hi_cnt_r <= CNT_ONE;
         end else if (inc_hi_s) begin
            hi_cnt_r <= hi_inc_s;
         end
         if (load_lo_s) begin
            lo_cnt_r <= CNT_ONE;
         end else if (inc_lo_s) begin
            lo_cnt_r <= lo_inc_s;
         end
         if (capture_s) begin
            high_out   <= hi_cnt_r;
            low_out    <= lo_cnt_r;
            period_out <= period_s;
         end
         meas_valid <= capture_s;
      end
   end

   // Edge-free cycle counter and the stalled flag.
   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         st_cnt_r <= CNT_ZERO;
         stalled  <= 1'b0;
      end else begin
         if (edge_s) begin
            st_cnt_r <= CNT_ZERO;
         end else if (st_cnt_r != TMO_VAL) begin
            st_cnt_r <= st_cnt_r + CNT_ONE;
         end
         if (edge_s) begin
            stalled <= 1'b0;
         end else if (stall_hit_s) begin
            stalled <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_clock_period_meter.sv
// ---------------------------------------------------------------------------
// tb_clock_period_meter
//
// Self-checking bench for clock_period_meter. Expected measurements (with
// the cycle in which meas_valid must appear) are queued when the rising edge
// that completes a period is driven, and popped when the DUT pulses.
// A second, narrow instance exercises period saturation.
// ---------------------------------------------------------------------------
module tb_clock_period_meter;

   localparam int CNT_W  = 28;
   localparam int TMO    = 100;
   localparam int S_W    = 4;
   localparam int S_TMO  = 15;

   typedef struct {
      int hi;
      int lo;
      int per;
      int cyc;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             sig_in = 1'b0;
   logic             sig_sat = 1'b0;

   logic             level;
   logic [CNT_W-1:0] high_out;
   logic [CNT_W-1:0] low_out;
   logic [CNT_W-1:0] period_out;
   logic             meas_valid;
   logic             stalled;

   logic             s_level;
   logic [S_W-1:0]   s_high;
   logic [S_W-1:0]   s_low;
   logic [S_W-1:0]   s_period;
   logic             s_valid;
   logic             s_stalled;

   int               cnt = 0;
   int               n_tests = 0;
   int               n_fail = 0;
   int               c;
   exp_t             sb_q[$];
   exp_t             sat_q[$];
   exp_t             m_e;
   exp_t             s_e;

   clock_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TMO)) u_dut (
      .clk_in     (clk),
      .rst_n      (rst_n),
      .sig_in     (sig_in),
      .level      (level),
      .high_out   (high_out),
      .low_out    (low_out),
      .period_out (period_out),
      .meas_valid (meas_valid),
      .stalled    (stalled)
   );

   clock_period_meter #(.CNT_W(S_W), .TIMEOUT(S_TMO)) u_sat (
      .clk_in     (clk),
      .rst_n      (rst_n),
      .sig_in     (sig_sat),
      .level      (s_level),
      .high_out   (s_high),
      .low_out    (s_low),
      .period_out (s_period),
      .meas_valid (s_valid),
      .stalled    (s_stalled)
   );

   always #5 clk = ~clk;

   // Free-running cycle index used to time-stamp expectations.
   always @(posedge clk) cnt <= cnt + 1;

   task automatic check_val(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cnt);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic half(input logic v, input int n);
      sig_in = v;
      cyc(n);
   endtask

   task automatic half_s(input logic v, input int n);
      sig_sat = v;
      cyc(n);
   endtask

   // Call right before driving the rising edge that completes a period.
   task automatic push(input int h, input int l, input int p);
      exp_t e;
      e = '{h, l, p, cnt + 3};
      sb_q.push_back(e);
   endtask

   task automatic push_s(input int h, input int l, input int p);
      exp_t e;
      e = '{h, l, p, cnt + 3};
      sat_q.push_back(e);
   endtask

   task automatic wait_cnt(input int t);
      do @(negedge clk); while (cnt < t);
   endtask

   task automatic check_zero(input string tag);
      check_val({tag, "_high"},   int'(high_out),   0);
      check_val({tag, "_low"},    int'(low_out),    0);
      check_val({tag, "_period"}, int'(period_out), 0);
      check_val({tag, "_valid"},  int'(meas_valid), 0);
      check_val({tag, "_stalled"}, int'(stalled),   0);
   endtask

   // Scoreboard for the main instance.
   always @(negedge clk) begin
      if (meas_valid) begin
         if (sb_q.size() == 0) begin
            check_val("main_spurious_pulse", 1, 0);
         end else begin
            m_e = sb_q.pop_front();
            check_val("main_high",   int'(high_out),   m_e.hi);
            check_val("main_low",    int'(low_out),    m_e.lo);
            check_val("main_period", int'(period_out), m_e.per);
            check_val("main_cycle",  cnt,              m_e.cyc);
         end
      end
   end

   // Scoreboard for the saturation instance.
   always @(negedge clk) begin
      if (s_valid) begin
         if (sat_q.size() == 0) begin
            check_val("sat_spurious_pulse", 1, 0);
         end else begin
            s_e = sat_q.pop_front();
            check_val("sat_high",   int'(s_high),   s_e.hi);
            check_val("sat_low",    int'(s_low),    s_e.lo);
            check_val("sat_period", int'(s_period), s_e.per);
            check_val("sat_cycle",  cnt,            s_e.cyc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset with sig_in toggling.
      rst_n  = 1'b0;
      sig_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         sig_in = ~sig_in;
      end
      @(negedge clk);
      check_zero("reset");
      check_val("reset_level", int'(level), 0);

      // Release with sig_in already high: truncated first high is ignored.
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      sig_in = 1'b1;
      c = cnt;
      wait_cnt(c + 1);
      check_val("level_lat1", int'(level), 0);
      wait_cnt(c + 2);
      check_val("level_lat2", int'(level), 1);
      @(posedge clk);
      #1;
      cyc(17);
      half(1'b0, 4);
      half(1'b1, 4);
      half(1'b0, 4);
      push(4, 4, 8);
      half(1'b1, 4);
      half(1'b0, 4);
      push(4, 4, 8);
      half(1'b1, 4);

      // Steady 5/3 stream.
      half(1'b0, 3);
      push(4, 3, 7);
      half(1'b1, 5);
      for (int i = 0; i < 3; i++) begin
         half(1'b0, 3);
         push(5, 3, 8);
         half(1'b1, 5);
      end

      // Stop toggling: stall exactly TMO cycles after the fall is detected.
      sig_in = 1'b0;
      c = cnt;
      wait_cnt(c + 2 + TMO);
      check_val("stall_early", int'(stalled), 0);
      wait_cnt(c + 3 + TMO);
      check_val("stall_set", int'(stalled), 1);
      check_val("stall_hold_high",   int'(high_out),   5);
      check_val("stall_hold_low",    int'(low_out),    3);
      check_val("stall_hold_period", int'(period_out), 8);

      // Resume with 6/6: stalled drops at the first edge-detect cycle.
      @(posedge clk);
      #1;
      sig_in = 1'b1;
      c = cnt;
      wait_cnt(c + 2);
      check_val("stall_still", int'(stalled), 1);
      wait_cnt(c + 3);
      check_val("stall_clear", int'(stalled), 0);
      @(posedge clk);
      #1;
      cyc(2);
      half(1'b0, 6);
      push(6, 6, 12);
      half(1'b1, 5);
      half(1'b0, 3);
      push(5, 3, 8);
      half(1'b1, 5);

      // Reset in the middle of a low phase.
      half(1'b0, 1);
      rst_n = 1'b0;
      cyc(2);
      @(negedge clk);
      check_zero("midreset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(2);
      half(1'b1, 5);
      half(1'b0, 3);
      push(5, 3, 8);
      half(1'b1, 5);
      half(1'b0, 3);

      // Saturating period on the 4-bit instance.
      half_s(1'b1, 15);
      half_s(1'b0, 3);
      push_s(15, 3, 15);
      half_s(1'b1, 12);
      half_s(1'b0, 10);
      push_s(12, 10, 15);
      half_s(1'b1, 4);
      half_s(1'b0, 3);

      cyc(10);
      check_val("main_sb_drained", sb_q.size(), 0);
      check_val("sat_sb_drained", sat_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
